// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and grant decision for the two-master Wishbone arbiter.
// WB_ARB_FIXED_PRIO_EN selects fixed m0-first priority instead of round-robin.
package wb_arb_pkg;
  localparam int NB_MASTERS = 2;
  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = WB_DW / 8;
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} arb_state_t;
  // last names the master granted most recently (0 = m0, 1 = m1)
  function automatic arb_state_t next_grant(input logic [NB_MASTERS-1:0] req, input logic last);
`ifdef WB_ARB_FIXED_PRIO_EN
    return req[0] ? GNT0 : req[1] ? GNT1 : IDLE;
`else
    return req == 2'b11 ? (last ? GNT0 : GNT1) : req[0] ? GNT0 : req[1] ? GNT1 : IDLE;
`endif
  endfunction
endpackage

// File: rtl/wshb_if.sv
// wshb_if: classic Wishbone bus bundle shared by masters and slaves of the arbiter.
interface wshb_if import wb_arb_pkg::*; (input logic clk);
  logic [WB_AW-1:0] adr;
  logic [WB_DW-1:0] dat_ms;
  logic [WB_DW-1:0] dat_sm;
  logic [WB_SW-1:0] sel;
  logic we;
  logic stb;
  logic cyc;
  logic ack;
  logic err;
  logic rty;
  modport master(input clk, output adr, dat_ms, sel, we, stb, cyc, input dat_sm, ack, err, rty);
  modport slave(input clk, input adr, dat_ms, sel, we, stb, cyc, output dat_sm, ack, err, rty);
endinterface

// File: rtl/wb_arb_fsm.sv
// wb_arb_fsm: grant state machine, priority pointer and saturating grant counters.
// WB_ARB_FIXED_PRIO_EN removes the round-robin pointer (m0 always wins ties).
module wb_arb_fsm import wb_arb_pkg::*; #(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NB_MASTERS-1:0] req_i,
  output logic [NB_MASTERS-1:0] grant_o,
  output logic [CNT_W-1:0]      gnt_cnt0_o,
  output logic [CNT_W-1:0]      gnt_cnt1_o
);
  arb_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic inc0, inc1, last;
`ifdef WB_ARB_FIXED_PRIO_EN
  assign last = 1'b1;
`else
  logic last_q, last_d;
  assign last = last_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  always_comb last_d = inc0 ? 1'b0 : inc1 ? 1'b1 : last_q;
`endif
  // a grant is held for the whole CYC; the decision is only re-taken once CYC drops
  always_comb begin
    state_d = state_q == GNT0 && req_i[0] ? GNT0 :
              state_q == GNT1 && req_i[1] ? GNT1 : next_grant(req_i, last);
    inc0    = state_d == GNT0 && !(state_q == GNT0 && req_i[0]);
    inc1    = state_d == GNT1 && !(state_q == GNT1 && req_i[1]);
    cnt0_d  = inc0 && cnt0_q != '1 ? cnt0_q + CNT_W'(1) : cnt0_q;
    cnt1_d  = inc1 && cnt1_q != '1 ? cnt1_q + CNT_W'(1) : cnt1_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  assign grant_o    = {state_q == GNT1, state_q == GNT0};
  assign gnt_cnt0_o = cnt0_q;
  assign gnt_cnt1_o = cnt1_q;
endmodule

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: shares one Wishbone slave between two masters, CYC-granular arbitration.
// Define WB_ARB_FIXED_PRIO_EN for fixed m0 priority; round-robin otherwise.
module wb_arbiter_2m import wb_arb_pkg::*; #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  wshb_if.slave            wb_m0,
  wshb_if.slave            wb_m1,
  wshb_if.master           wb_s,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);
  logic g0, g1;
  wb_arb_fsm #(.CNT_W(CNT_W)) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .req_i      ({wb_m1.cyc, wb_m0.cyc}),
    .grant_o    (grant),
    .gnt_cnt0_o (gnt_cnt0),
    .gnt_cnt1_o (gnt_cnt1)
  );
  assign g0 = grant[0];
  assign g1 = grant[1];
  assign wb_s.cyc    = (g0 & wb_m0.cyc) | (g1 & wb_m1.cyc);
  assign wb_s.stb    = (g0 & wb_m0.stb) | (g1 & wb_m1.stb);
  assign wb_s.we     = (g0 & wb_m0.we)  | (g1 & wb_m1.we);
  assign wb_s.adr    = g1 ? wb_m1.adr    : g0 ? wb_m0.adr    : '0;
  assign wb_s.dat_ms = g1 ? wb_m1.dat_ms : g0 ? wb_m0.dat_ms : '0;
  assign wb_s.sel    = g1 ? wb_m1.sel    : g0 ? wb_m0.sel    : '0;
  // responses after the owner dropped CYC are discarded rather than routed
  assign wb_m0.ack    = g0 & wb_m0.cyc & wb_s.ack;
  assign wb_m0.err    = g0 & wb_m0.cyc & wb_s.err;
  assign wb_m0.rty    = g0 & wb_m0.cyc & wb_s.rty;
  assign wb_m1.ack    = g1 & wb_m1.cyc & wb_s.ack;
  assign wb_m1.err    = g1 & wb_m1.cyc & wb_s.err;
  assign wb_m1.rty    = g1 & wb_m1.cyc & wb_s.rty;
  assign wb_m0.dat_sm = wb_s.dat_sm;
  assign wb_m1.dat_sm = wb_s.dat_sm;
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb_wb_arbiter_2m: directed checks of wb_arbiter_2m against a small memory slave.
module tb_wb_arbiter_2m;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  wshb_if m0 (.clk(clk));
  wshb_if m1 (.clk(clk));
  wshb_if s  (.clk(clk));
  logic [1:0]  grant;
  logic [15:0] c0, c1;
  int vecs = 0;
  int errs = 0;
  int n;
  wb_arbiter_2m #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .wb_m0(m0), .wb_m1(m1), .wb_s(s),
    .grant(grant), .gnt_cnt0(c0), .gnt_cnt1(c1)
  );
  // memory slave: one wait state, error response at address 0xEE
  logic [31:0] mem [16];
  logic resp;
  always @(posedge clk or posedge rst)
    if (rst) resp <= 1'b0;
    else begin
      resp <= s.cyc & s.stb & !resp;
      if (s.cyc & s.stb & s.we & !resp) mem[s.adr[5:2]] <= s.dat_ms;
    end
  assign s.ack    = resp & (s.adr[7:0] != 8'hEE);
  assign s.err    = resp & (s.adr[7:0] == 8'hEE);
  assign s.rty    = 1'b0;
  assign s.dat_sm = mem[s.adr[5:2]];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ack(input int m, input string tag);
    int k = 0;
    while (!(m == 1 ? m1.ack : m0.ack) && k < 8) begin
      tick;
      k++;
    end
    chk(tag, 32'(k < 8), 32'd1);
  endtask
  task automatic drive0(input logic c, input logic st, input logic w, input logic [31:0] a, input logic [31:0] d);
    m0.cyc = c; m0.stb = st; m0.we = w; m0.adr = a; m0.dat_ms = d; m0.sel = 4'hF;
  endtask
  task automatic drive1(input logic c, input logic st, input logic w, input logic [31:0] a, input logic [31:0] d);
    m1.cyc = c; m1.stb = st; m1.we = w; m1.adr = a; m1.dat_ms = d; m1.sel = 4'hF;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);
    tick;
    chk("rst_grant", grant, 2'b00);
    chk("rst_cnt0", c0, 0);
    chk("rst_cnt1", c1, 0);
    chk("rst_scyc", s.cyc, 0);
    chk("rst_sstb", s.stb, 0);
    chk("rst_m0ack", m0.ack, 0);
    rst = 1'b0;
    tick;
    // single master write then read back
    drive0(1, 1, 1, 32'h10, 32'hDEADBEEF);
    #1;
    chk("t1_pre_grant", grant, 2'b00);
    chk("t1_pre_scyc", s.cyc, 0);
    tick;
    chk("t1_grant_w", grant, 2'b01);
    chk("t1_sadr", s.adr, 32'h10);
    wait_ack(0, "t1_wack");
    chk("t1_m1_noack_w", m1.ack, 0);
    chk("t1_grant_wack", grant, 2'b01);
    drive0(0, 0, 0, 0, 0);
    tick;
    chk("t1_idle", grant, 2'b00);
    drive0(1, 1, 0, 32'h10, 0);
    tick;
    chk("t1_grant_r", grant, 2'b01);
    wait_ack(0, "t1_rack");
    chk("t1_rdata", m0.dat_sm, 32'hDEADBEEF);
    chk("t1_bcast", m1.dat_sm, 32'hDEADBEEF);
    chk("t1_m1_noack_r", m1.ack, 0);
    drive0(0, 0, 0, 0, 0);
    tick;
    chk("t1_cnt0", c0, 2);
    chk("t1_cnt1", c1, 0);
    // simultaneous requests right after reset
    rst = 1'b1;
    #1;
    rst = 1'b0;
    drive0(1, 1, 1, 32'h20, 32'h1);
    drive1(1, 1, 1, 32'h24, 32'h2);
    tick;
    chk("t2_first", grant, 2'b01);
    chk("t2_sadr", s.adr, 32'h20);
    wait_ack(0, "t2_ack0");
    chk("t2_m1_wait", m1.ack, 0);
    drive0(0, 0, 0, 0, 0);
    tick;
    chk("t2_handover", grant, 2'b10);
    wait_ack(1, "t2_ack1");
    drive1(0, 0, 0, 0, 0);
    tick;
    chk("t2_idle", grant, 2'b00);
    chk("t2_cnt0", c0, 1);
    chk("t2_cnt1", c1, 1);
    // round robin with back-to-back cycles from both masters
    drive0(1, 1, 1, 32'h30, 32'h3);
    drive1(1, 1, 1, 32'h34, 32'h4);
    tick;
    for (int k = 0; k < 6; k++) begin
      chk("t3_rr", grant, k % 2 == 1 ? 2'b10 : 2'b01);
      wait_ack(k % 2, "t3_ack");
      if (k % 2 == 1) drive1(0, 0, 0, 0, 0);
      else drive0(0, 0, 0, 0, 0);
      tick;
      if (k % 2 == 1) drive1(1, 1, 1, 32'h34, 32'h4);
      else drive0(1, 1, 1, 32'h30, 32'h3);
    end
    chk("t3_rr_last", grant, 2'b01);
    chk("t3_cnt0", c0, 5);
    chk("t3_cnt1", c1, 4);
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);
    tick;
    tick;
    // m1 holds its cycle for eight writes while m0 waits
    drive1(1, 1, 1, 32'h40, 32'h55);
    tick;
    chk("t4_grant1", grant, 2'b10);
    drive0(1, 1, 1, 32'h44, 32'h66);
    n = 0;
    repeat (16) begin
      tick;
      chk("t4_m0_noack", m0.ack, 0);
      chk("t4_sadr", s.adr, 32'h40);
      if (m1.ack) n++;
    end
    chk("t4_m1_acks", n, 8);
    chk("t4_hold", grant, 2'b10);
    drive1(0, 0, 0, 0, 0);
    tick;
    chk("t4_grant0", grant, 2'b01);
    wait_ack(0, "t4_ack0");
    drive0(0, 0, 0, 0, 0);
    tick;
    chk("t4_cnt1", c1, 5);
    // asynchronous reset in the middle of a read
    drive0(1, 1, 0, 32'h10, 0);
    tick;
    chk("t5_grant", grant, 2'b01);
    chk("t5_noack_yet", m0.ack, 0);
    rst = 1'b1;
    #1;
    chk("t5_grant_rst", grant, 2'b00);
    chk("t5_scyc_rst", s.cyc, 0);
    chk("t5_sstb_rst", s.stb, 0);
    chk("t5_cnt0_rst", c0, 0);
    chk("t5_cnt1_rst", c1, 0);
    tick;
    chk("t5_m0_noack1", m0.ack, 0);
    tick;
    chk("t5_m0_noack2", m0.ack, 0);
    drive0(0, 0, 0, 0, 0);
    rst = 1'b0;
    tick;
    // error response routed only to the owner
    drive1(1, 1, 0, 32'hEE, 0);
    tick;
    chk("t6_grant", grant, 2'b10);
    tick;
    chk("t6_m1_err", m1.err, 1);
    chk("t6_m1_noack", m1.ack, 0);
    chk("t6_m0_noerr", m0.err, 0);
    drive1(0, 0, 0, 0, 0);
    tick;
    chk("t6_idle", grant, 2'b00);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
